// File: rtl/unsat_clause_collector.sv
// Collects clauses whose true-literal count drops to zero during a flip epoch
// into a first-word-fall-through FIFO drained by the unsat clause selector.
module unsat_clause_collector #(
    parameter  int unsigned NSAT                  = 3,
    parameter  int unsigned LITERAL_ADDRESS_WIDTH = 12,
    parameter  int unsigned FIFO_DEPTH            = 16,
    localparam int unsigned CLAUSE_WIDTH          = NSAT * LITERAL_ADDRESS_WIDTH,
    localparam int unsigned TCW                   = $clog2(NSAT + 1),
    localparam int unsigned CW                    = $clog2(FIFO_DEPTH + 1),
    localparam int unsigned PW                    = $clog2(FIFO_DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flip_start_i,
    input  logic                    eval_valid_i,
    input  logic [CLAUSE_WIDTH-1:0] eval_clause_i,
    input  logic [TCW-1:0]          eval_true_count_i,
    input  logic                    eval_done_i,
    input  logic                    pop_i,
    output logic                    fifo_empty_o,
    output logic [CLAUSE_WIDTH-1:0] fifo_clause_o,
    output logic                    fifo_last_o,
    output logic [CW-1:0]           count_o,
    output logic                    busy_o,
    output logic                    drain_done_o,
    output logic                    overflow_o,
    output logic                    protocol_err_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    w_drain_fire;
    logic                    w_proto_err;

    logic [CLAUSE_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]           r_wr_ptr;
    logic [PW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_count;
    logic                    r_drain_done;
    logic                    r_overflow;
    logic                    r_proto_err;

    logic                    w_empty;
    logic                    w_full;
    logic                    w_push;
    logic                    w_push_acc;
    logic                    w_pop_acc;
    logic                    w_drop;

    assign w_empty    = (r_count == CW'(0));
    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_push     = eval_valid_i & (eval_true_count_i == TCW'(0)) & (r_state == S_COLLECT);
    // Pop on empty is silently ignored: the selector may pop speculatively.
    assign w_pop_acc  = pop_i & ~w_empty;
    assign w_push_acc = w_push & (~w_full | w_pop_acc);
    assign w_drop     = w_push & w_full & ~w_pop_acc;

    // Next-state, drain completion and protocol checks.
    always_comb begin
        w_state_next = r_state;
        w_drain_fire = 1'b0;
        w_proto_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_proto_err = eval_valid_i | eval_done_i;
                if (flip_start_i) begin
                    w_state_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                w_proto_err = flip_start_i;
                if (eval_done_i) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_proto_err = flip_start_i | eval_valid_i | eval_done_i;
                if (w_empty) begin
                    w_state_next = S_IDLE;
                    w_drain_fire = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, pointers, occupancy and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= PW'(0);
            r_rd_ptr     <= PW'(0);
            r_count      <= CW'(0);
            r_drain_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_proto_err  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_drain_done <= w_drain_fire;
            r_overflow   <= r_overflow | w_drop;
            r_proto_err  <= r_proto_err | w_proto_err;
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= eval_clause_i;
        end
    end

    assign fifo_empty_o   = w_empty;
    assign fifo_clause_o  = w_empty ? CLAUSE_WIDTH'(0) : r_mem[r_rd_ptr];
    assign fifo_last_o    = (r_state == S_DRAIN) & (r_count == CW'(1));
    assign count_o        = r_count;
    assign busy_o         = (r_state != S_IDLE);
    assign drain_done_o   = r_drain_done;
    assign overflow_o     = r_overflow;
    assign protocol_err_o = r_proto_err;

endmodule

// File: tb/tb_unsat_clause_collector.sv
// Directed bench for unsat_clause_collector with a queue scoreboard and a
// small reference model of the epoch state machine.
module tb_unsat_clause_collector;

    localparam int unsigned CLW   = 36;
    localparam int unsigned DEPTH = 16;

    localparam int M_IDLE    = 0;
    localparam int M_COLLECT = 1;
    localparam int M_DRAIN   = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            flip_start_i;
    logic            eval_valid_i;
    logic [CLW-1:0]  eval_clause_i;
    logic [1:0]      eval_true_count_i;
    logic            eval_done_i;
    logic            pop_i;
    logic            fifo_empty_o;
    logic [CLW-1:0]  fifo_clause_o;
    logic            fifo_last_o;
    logic [4:0]      count_o;
    logic            busy_o;
    logic            drain_done_o;
    logic            overflow_o;
    logic            protocol_err_o;

    int              checks   = 0;
    int              failures = 0;

    logic [CLW-1:0]  sb_q [$];
    int              m_state = M_IDLE;
    logic            m_dd    = 1'b0;
    logic            m_ovf   = 1'b0;
    logic            m_perr  = 1'b0;

    unsat_clause_collector dut (
        .clk               (clk),
        .reset             (reset),
        .flip_start_i      (flip_start_i),
        .eval_valid_i      (eval_valid_i),
        .eval_clause_i     (eval_clause_i),
        .eval_true_count_i (eval_true_count_i),
        .eval_done_i       (eval_done_i),
        .pop_i             (pop_i),
        .fifo_empty_o      (fifo_empty_o),
        .fifo_clause_o     (fifo_clause_o),
        .fifo_last_o       (fifo_last_o),
        .count_o           (count_o),
        .busy_o            (busy_o),
        .drain_done_o      (drain_done_o),
        .overflow_o        (overflow_o),
        .protocol_err_o    (protocol_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = sb_q.size();
        chk("count", 64'(count_o), 64'(sz));
        chk("empty", 64'(fifo_empty_o), 64'(sz == 0));
        chk("head", 64'(fifo_clause_o), (sz == 0) ? 64'(0) : 64'(sb_q[0]));
        chk("last", 64'(fifo_last_o), 64'((m_state == M_DRAIN) && (sz == 1)));
        chk("busy", 64'(busy_o), 64'(m_state != M_IDLE));
        chk("drain_done", 64'(drain_done_o), 64'(m_dd));
        chk("overflow", 64'(overflow_o), 64'(m_ovf));
        chk("protocol_err", 64'(protocol_err_o), 64'(m_perr));
    endtask

    task automatic clear_inputs();
        flip_start_i      = 1'b0;
        eval_valid_i      = 1'b0;
        eval_clause_i     = '0;
        eval_true_count_i = 2'd1;
        eval_done_i       = 1'b0;
        pop_i             = 1'b0;
    endtask

    // One clock of stimulus; called at a falling edge, returns at the next one.
    task automatic step(input logic flip, input logic ev, input logic [CLW-1:0] clause,
                        input logic [1:0] tc, input logic done, input logic pop);
        int sz;
        int st;
        sz = sb_q.size();
        st = m_state;
        flip_start_i      = flip;
        eval_valid_i      = ev;
        eval_clause_i     = clause;
        eval_true_count_i = tc;
        eval_done_i       = done;
        pop_i             = pop;
        if (pop && sz > 0) begin
            chk("pop_head", 64'(fifo_clause_o), 64'(sb_q[0]));
            void'(sb_q.pop_front());
        end
        if (st == M_COLLECT && ev && tc == 2'd0) begin
            if (sb_q.size() < DEPTH) sb_q.push_back(clause);
            else m_ovf = 1'b1;
        end
        if (flip && st != M_IDLE) m_perr = 1'b1;
        if ((ev || done) && st != M_COLLECT) m_perr = 1'b1;
        m_dd = 1'b0;
        case (st)
            M_IDLE:    if (flip) m_state = M_COLLECT;
            M_COLLECT: if (done) m_state = M_DRAIN;
            default: if (sz == 0) begin
                m_state = M_IDLE;
                m_dd    = 1'b1;
            end
        endcase
        @(negedge clk);
        clear_inputs();
        check_all();
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, '0, 2'd1, 1'b0, 1'b0);
    endtask

    task automatic pop_step();
        step(1'b0, 1'b0, '0, 2'd1, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
        m_state = M_IDLE;
        m_dd    = 1'b0;
        m_ovf   = 1'b0;
        m_perr  = 1'b0;
        check_all();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        do_reset();
        repeat (5) idle_step();

        // Basic epoch: A,C unsatisfied; B,D not.
        step(1'b1, 1'b0, '0, 2'd1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 36'h0000_000A1, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 36'h0000_000B2, 2'd1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 36'h0000_000C3, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 36'h0000_000D4, 2'd2, 1'b1, 1'b0);
        chk("basic_count2", 64'(count_o), 64'd2);
        idle_step();
        pop_step();
        chk("basic_last_C", 64'(fifo_last_o), 64'd1);
        idle_step();
        pop_step();
        idle_step();
        chk("basic_drain_pulse", 64'(drain_done_o), 64'd1);
        idle_step();
        idle_step();

        // Overflow: 17 pushes into 16 entries, last eval closes the epoch.
        step(1'b1, 1'b0, '0, 2'd1, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++)
            step(1'b0, 1'b1, 36'(32'h100 + i), 2'd0, (i == 16), 1'b0);
        chk("ovf_flag", 64'(overflow_o), 64'd1);
        for (int i = 0; i < 16; i++) pop_step();
        repeat (3) idle_step();

        // Full FIFO with simultaneous push and pop across pointer wrap.
        do_reset();
        step(1'b1, 1'b0, '0, 2'd1, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b1, 36'(32'h200 + i), 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b1, 36'(32'h300 + i), 2'd0, (i == 19), 1'b1);
        chk("full_count16", 64'(count_o), 64'd16);
        for (int i = 0; i < 16; i++) pop_step();
        repeat (3) idle_step();

        // Protocol errors and speculative pop on empty.
        do_reset();
        pop_step();
        chk("pop_empty_noerr", 64'(protocol_err_o), 64'd0);
        step(1'b0, 1'b1, 36'h0000_00EE0, 2'd0, 1'b0, 1'b0);
        chk("eval_in_idle_err", 64'(protocol_err_o), 64'd1);
        step(1'b1, 1'b0, '0, 2'd1, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 2'd1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 36'h0000_00F01, 2'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, '0, 2'd1, 1'b1, 1'b0);
        pop_step();
        repeat (3) idle_step();

        // Reset while draining three entries, then a fresh epoch.
        do_reset();
        step(1'b1, 1'b0, '0, 2'd1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 36'h1_2345_6781, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 36'h1_2345_6782, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 36'h1_2345_6783, 2'd0, 1'b1, 1'b0);
        chk("drain_count3", 64'(count_o), 64'd3);
        do_reset();
        idle_step();
        step(1'b1, 1'b0, '0, 2'd1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 36'hF_FFFF_FFF1, 2'd0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 36'hF_FFFF_FFF2, 2'd3, 1'b0, 1'b0);
        step(1'b0, 1'b1, 36'hF_FFFF_FFF3, 2'd0, 1'b1, 1'b1);
        pop_step();
        repeat (3) idle_step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
